ram_burst_reader: RTL and testbench

//  Read-side initiator for the 256x8 dual-port RAM. Drives one RAM port's address/output_enable.

---
 rtl/dpram_pkg.sv | 38 +++
 rtl/ram_rd_skid_buf.sv | 65 ++++++
 rtl/ram_burst_reader.sv | 228 ++++++++++++++++++++++
 tb/tb_ram_burst_reader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// ---------------------------------------------------------------------------
// dpram_pkg
//   Shared definitions for users of the 256x8 dual-port RAM.
//
//   Contents:
//     DPRAM_ADDR_WIDTH / DPRAM_DATA_WIDTH / DPRAM_DEPTH
//         Default geometry of the RAM. Blocks that talk to the RAM take
//         these as their parameter defaults.
//     RD_IDLE / RD_ISSUE / RD_DRAIN
//         State encoding of the burst reader FSM.
//     rd_state_e
//         Enum built on that encoding. The encoding is pinned so that
//         waveforms and external checkers can decode the state value.
//     beat_width()
//         Width of one buffered beat ({last, data}) for a given data width.
// ---------------------------------------------------------------------------
package dpram_pkg;

    localparam int DPRAM_ADDR_WIDTH = 8;
    localparam int DPRAM_DATA_WIDTH = 8;
    localparam int DPRAM_DEPTH      = 1 << DPRAM_ADDR_WIDTH;

    localparam logic [1:0] RD_IDLE  = 2'd0;
    localparam logic [1:0] RD_ISSUE = 2'd1;
    localparam logic [1:0] RD_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = RD_IDLE,
        ISSUE = RD_ISSUE,
        DRAIN = RD_DRAIN
    } rd_state_e;

    // One buffered beat is the data word plus its end-of-burst tag.
    function automatic int beat_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/ram_rd_skid_buf.sv
// ---------------------------------------------------------------------------
// ram_rd_skid_buf
//   Two-entry FIFO holding read beats ({last, data}) between the RAM read
//   port and the output stream. The reader only issues a RAM read when a
//   slot is guaranteed to be free on the cycle the data returns, so the
//   FIFO never sees a push while full.
//
//   Ports:
//     clk        in   1              clock, posedge
//     rst        in   1              synchronous active-high reset, empties FIFO
//     push       in   1              write {push_last, push_data}
//     push_data  in   DATA_WIDTH     data word to store
//     push_last  in   1              end-of-burst tag to store
//     pop        in   1              drop the head entry (only when count != 0)
//     count      out  2              number of stored entries, 0..2
//     head       out  DATA_WIDTH+1   oldest entry, {last, data}
//
//   Push and pop in the same cycle are both honoured; count stays the same.
// ---------------------------------------------------------------------------
module ram_rd_skid_buf
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH = DPRAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic [DATA_WIDTH:0]   head
);

    localparam int BW = beat_width(DATA_WIDTH);

    logic [BW-1:0] slot_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;

    // Slots are cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                slot_q[wr_ptr_q] <= {push_last, push_data};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count = count_q;
    assign head  = slot_q[rd_ptr_q];

endmodule

// File: rtl/ram_burst_reader.sv
// ---------------------------------------------------------------------------
// ram_burst_reader
//   Read-side initiator for the dual-port RAM. Takes a burst command
//   (start address, beat count minus one), drives one RAM port's address and
//   output enable, and streams the returned words out on a valid/ready
//   interface. The RAM has one cycle of registered read latency; a 2-entry
//   buffer plus a credit check absorb that latency and downstream stalls.
//
//   Parameters:
//     ADDR_WIDTH  RAM address width, also the width of cmd_len
//     DATA_WIDTH  RAM data width
//     DEPTH       number of RAM locations; last address is DEPTH-1
//
//   Ports:
//     clk        in   1           clock, posedge
//     rst        in   1           synchronous active-high reset
//     cmd_valid  in   1           burst command valid
//     cmd_ready  out  1           high only in IDLE
//     cmd_addr   in   ADDR_WIDTH  burst start address
//     cmd_len    in   ADDR_WIDTH  beats minus one
//     ram_addr   out  ADDR_WIDTH  RAM address (holds last issued value)
//     ram_oe     out  1           RAM output enable, data returns next cycle
//     ram_rdata  in   DATA_WIDTH  RAM read data
//     m_valid    out  1           stream beat valid
//     m_ready    in   1           stream beat accepted
//     m_data     out  DATA_WIDTH  beat data
//     m_last     out  1           final beat of the burst
//     busy       out  1           FSM not in IDLE
//     done       out  1           one-cycle pulse on the return to IDLE
//     trunc      out  1           pulses with done if the burst hit DEPTH-1 early
//
//   Handshake: on both cmd_* and m_*, a transfer happens on a rising clk edge
//   where valid && ready. The stream side never withdraws or changes a beat
//   while m_valid && !m_ready; cmd_* is only looked at on the accepting edge.
//
//   Build option BURST_READER_WRAP_EN:
//     defined   - bursts wrap DEPTH-1 -> 0 and always deliver cmd_len+1 beats;
//                 trunc is tied low.
//     undefined - the beat read from DEPTH-1 ends the burst; trunc pulses with
//                 done when beats were still outstanding at that point.
// ---------------------------------------------------------------------------
module ram_burst_reader
    import dpram_pkg::*;
#(
    parameter int ADDR_WIDTH = DPRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DPRAM_DATA_WIDTH,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_oe,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic                  trunc
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    rd_state_e             state_q;
    rd_state_e             state_d;

    logic [ADDR_WIDTH-1:0] cur_q;          // next address to read
    logic [ADDR_WIDTH-1:0] rem_q;          // reads left after the next one
    logic [ADDR_WIDTH-1:0] ram_addr_q;     // address of the most recent read
    logic                  inflight_q;     // a read was issued last cycle
    logic                  inflight_last_q;// ...and it was the burst's final read

    logic [1:0]            buf_count;
    logic [DATA_WIDTH:0]   buf_head;
    logic                  pop;
    logic [2:0]            slots_used;
    logic                  credit_ok;
    logic                  issue;
    logic                  at_end;
    logic                  last_issue;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] cur_next;

`ifndef BURST_READER_WRAP_EN
    logic                  trunc_q;        // burst was cut short at LAST_ADDR
`endif

    // -----------------------------------------------------------------------
    // Credit: a read may be issued only if its data will find a free slot.
    // Slots in use = buffered beats + the read still coming back. A beat
    // leaving the buffer this cycle frees its slot before the new read's
    // data arrives, which is what allows one beat per cycle with m_ready high.
    // -----------------------------------------------------------------------
    assign pop        = m_valid && m_ready;
    assign slots_used = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok  = (slots_used < 3'd2);

    assign accept     = (state_q == IDLE) && cmd_valid;
    assign issue      = (state_q == ISSUE) && credit_ok;

`ifdef BURST_READER_WRAP_EN
    assign at_end     = 1'b0;
`else
    assign at_end     = (cur_q == LAST_ADDR);
`endif

    assign last_issue = issue && ((rem_q == '0) || at_end);

    // When DEPTH fills the address space this is the natural modulo wrap;
    // for a smaller RAM it keeps the read pointer inside the array.
    assign cur_next   = (cur_q == LAST_ADDR) ? '0 : cur_q + ADDR_WIDTH'(1);

    // -----------------------------------------------------------------------
    // FSM next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        trunc     = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (last_issue) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                // Leave only once the final read has landed and been taken.
                if (!inflight_q && (buf_count == 2'd0)) begin
                    state_d = IDLE;
                    done    = 1'b1;
`ifndef BURST_READER_WRAP_EN
                    trunc   = trunc_q;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, counters and read tracking
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cur_q           <= '0;
            rem_q           <= '0;
            ram_addr_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            // The read returning next cycle is pushed exactly once.
            inflight_q <= issue;

            if (accept) begin
                cur_q <= cmd_addr;
                rem_q <= cmd_len;
            end else if (issue) begin
                cur_q <= cur_next;
                rem_q <= rem_q - ADDR_WIDTH'(1);
            end

            if (issue) begin
                ram_addr_q      <= cur_q;
                inflight_last_q <= last_issue;
            end
        end
    end

`ifndef BURST_READER_WRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            trunc_q <= 1'b0;
        end else if (accept) begin
            trunc_q <= 1'b0;
        end else if (last_issue) begin
            // Stopped at LAST_ADDR with beats still owed.
            trunc_q <= at_end && (rem_q != '0);
        end
    end
`endif

    // RAM port: address follows cur on an issue cycle, otherwise holds.
    assign ram_oe   = issue;
    assign ram_addr = issue ? cur_q : ram_addr_q;

    // -----------------------------------------------------------------------
    // Read capture buffer and output stream
    // -----------------------------------------------------------------------
    ram_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (ram_rdata),
        .push_last (inflight_last_q),
        .pop       (pop),
        .count     (buf_count),
        .head      (buf_head)
    );

    assign m_valid = (buf_count != 2'd0);
    assign m_data  = buf_head[DATA_WIDTH-1:0];
    assign m_last  = m_valid && buf_head[DATA_WIDTH];

endmodule

// File: tb/tb_ram_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_burst_reader
//   Bench for ram_burst_reader paired with a behavioural 256x8 RAM holding
//   mem[i] = i ^ 8'hA5. Expected beats are queued when a command is sent and
//   compared as the stream delivers them. Honours BURST_READER_WRAP_EN.
// ---------------------------------------------------------------------------
module tb_ram_burst_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [7:0] ram_addr;
    logic       ram_oe;
    logic [7:0] ram_rdata;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic       done;
    logic       trunc;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    ram_burst_reader dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_addr  (ram_addr),
        .ram_oe    (ram_oe),
        .ram_rdata (ram_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .trunc     (trunc)
    );

    // ---------------- RAM model (1-cycle registered read) ----------------
    logic [7:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        ram_rdata = 8'h00;
    end
    always @(posedge clk) if (ram_oe) ram_rdata <= mem[ram_addr];

    // ---------------- scoreboard state ----------------
    logic [8:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_beats;
    logic       exp_trunc;
    int         acc_edge;
    int         burst_beats = 0;
    int         first_beat_cyc = 0;
    int         last_beat_cyc = 0;
    int         outstanding = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- stream monitor (samples on negedge) ----------------
    always @(negedge clk) begin
        logic       pop_now;
        logic [8:0] e;
        if (rst) begin
            outstanding = 0;
            prev_stall  = 1'b0;
            exp_q.delete();
        end else begin
            pop_now = m_valid && m_ready;
            if (cmd_valid && busy) check("cmd_ready_busy", cmd_ready, 0);
            if (cmd_valid && cmd_ready) begin
                burst_beats    = 0;
                first_beat_cyc = 0;
            end
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_beat", {m_last, m_data}, prev_beat);
            end
            if (ram_oe) check("credit", (outstanding - int'(pop_now)) < 2, 1);
            if (pop_now) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {m_last, m_data}, 9'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {m_last, m_data}, e);
                end
                if (burst_beats == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                burst_beats++;
            end
            outstanding = outstanding + int'(ram_oe) - int'(pop_now);
            prev_stall  = m_valid && !m_ready;
            prev_beat   = {m_last, m_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic model_burst(input logic [7:0] addr, input logic [7:0] len,
                               output int n, output logic tr);
        logic [7:0] a;
        logic [7:0] r;
        logic       last;
        a = addr; r = len; n = 0; tr = 1'b0;
        for (int i = 0; i < 256; i++) begin
`ifdef BURST_READER_WRAP_EN
            last = (r == 8'd0);
`else
            last = (r == 8'd0) || (a == 8'hFF);
            tr   = last && (r != 8'd0);
`endif
            exp_q.push_back({last, mem[a]});
            n++;
            if (last) break;
            a++;
            r--;
        end
    endtask

    task automatic send_cmd(input logic [7:0] addr, input logic [7:0] len);
        int   n;
        logic tr;
        model_burst(addr, len, n, tr);
        exp_beats = n;
        exp_trunc = tr;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        acc_edge = cyc + 1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = 8'($urandom_range(0, 255));
        cmd_len   = 8'($urandom_range(0, 255));
    endtask

    // mode 0: m_ready high; 1: m_ready 1,0,0 repeating; 2: m_ready high
    // with spurious cmd_valid pulses.
    task automatic wait_done(input int mode, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            case (mode)
                1: m_ready = (k % 3 == 0);
                2: begin
                    m_ready   = 1'b1;
                    cmd_valid = (k % 5 == 2);
                    cmd_addr  = 8'($urandom_range(0, 255));
                    cmd_len   = 8'($urandom_range(0, 255));
                end
                default: m_ready = 1'b1;
            endcase
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        check("done_seen", seen, 1);
        check("trunc", trunc, exp_trunc);
        check("beat_count", burst_beats, exp_beats);
        check("exp_empty", exp_q.size(), 0);
        check("done_after_last", cyc, last_beat_cyc + 1);
        if (mode != 1) check("no_gap", last_beat_cyc - first_beat_cyc, burst_beats - 1);
        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        check("idle_busy", busy, 0);
        check("done_pulse", done, 0);
        m_ready = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit hit;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_ram_oe", ram_oe, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_trunc", trunc, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b1;

        // 1: four beats from 0x10, read issued on the edge after acceptance,
        //    m_valid raised by the edge after that.
        send_cmd(8'h10, 8'd3);
        @(negedge clk);
        check("t1_issue_oe", ram_oe, 1);
        check("t1_issue_addr", ram_addr, 8'h10);
        check("t1_busy", busy, 1);
        check("t1_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        check("t1_not_yet_valid", m_valid, 0);
        @(negedge clk);
        check("t1_first_valid_cyc", cyc, acc_edge + 2);
        check("t1_first_valid", m_valid, 1);
        check("t1_first_data", m_data, 8'h10 ^ 8'hA5);
        wait_done(0, 40);

        // 2: backpressure 1,0,0 on eight beats.
        send_cmd(8'h20, 8'd7);
        wait_done(1, 120);

        // 3/4: burst crossing the top address.
        send_cmd(8'hFE, 8'd3);
        wait_done(0, 40);
`ifdef BURST_READER_WRAP_EN
        check("t4_beats", burst_beats, 4);
        check("t4_trunc_expected", exp_trunc, 0);
`else
        check("t3_beats", burst_beats, 2);
        check("t3_trunc_expected", exp_trunc, 1);
`endif

        // 5: reset mid-burst after the second beat.
        send_cmd(8'h00, 8'd15);
        hit = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (burst_beats >= 2) begin
                hit = 1'b1;
                break;
            end
        end
        check("t5_two_beats", hit, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_m_valid", m_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        send_cmd(8'h40, 8'd0);
        wait_done(0, 40);
        check("t5_single_beat", burst_beats, 1);

        // 6: full-depth burst with ignored command pulses.
        send_cmd(8'h00, 8'd255);
        wait_done(2, 400);
        check("t6_beats", burst_beats, 256);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
